rename_dispatch_ctrl: RTL
=========================

Name: rename_dispatch_ctrl

Overview:
Sequences the register file for each decoded instruction:
- Accepts one instruction.
- Presents rs1/rs2 to the register file's one-cycle registered read.
- Captures operand value or dependency.
- Renames rd to a freshly allocated ROB id through the register file's update port.
- Hands the result to reservation stations via a valid/ready handshake.

It owns the ROB tail pointer and occupancy count, so it back-pressures decode when the ROB is full.

Parameters:
ROB_WIDTH, 4, ROB id width; ROB depth = 2^ROB_WIDTH

Ports:
clockIn  in  1  clock
resetIn  in  1  synchronous active-high reset
flushIn  in  1  misprediction flush; clears in-flight state
instValid  in  1  decoded instruction valid
instReady  out  1  controller accepts instruction
instRs1  in  5  source register 1
instRs2  in  5  source register 2
instRd  in  5  destination register
instUseRs1  in  1  rs1 is a real operand
instUseRs2  in  1  rs2 is a real operand
instHasRd  in  1  instruction writes rd
instPayload  in  32  opaque op info, passed through unchanged
rfReg1  out  5  register file read address 1
rfReg2  out  5  register file read address 2
rs1Dirty  in  1  register file rs1 pending
rs1Dependency  in  ROB_WIDTH  register file rs1 producer id
rs1Value  in  32  register file rs1 value
rs2Dirty  in  1  register file rs2 pending
rs2Dependency  in  ROB_WIDTH  register file rs2 producer id
rs2Value  in  32  register file rs2 value
rfUpdateValid  out  1  rename strobe to register file
rfUpdateDest  out  5  renamed register
rfUpdateRobId  out  ROB_WIDTH  new producer id
robCommitValid  in  1  ROB retired one entry this cycle
issueValid  out  1  dispatch packet valid
issueReady  in  1  reservation station accepts
issueRobId  out  ROB_WIDTH  allocated ROB id
issueRd  out  5  destination (0 if !instHasRd)
issueRs1Dirty  out  1  captured rs1 dirty
issueRs1Dep  out  ROB_WIDTH  captured rs1 dependency
issueRs1Value  out  32  captured rs1 value
issueRs2Dirty  out  1  captured rs2 dirty
issueRs2Dep  out  ROB_WIDTH  captured rs2 dependency
issueRs2Value  out  32  captured rs2 value
issuePayload  out  32  latched instPayload

Behaviour:
- FSM states: IDLE, READ, ISSUE.
- instReady = (state==IDLE) && occupancy < 2^ROB_WIDTH && !flushIn && !resetIn.
- IDLE: on instValid&&instReady, latch all inst fields and go to READ. rfReg1/rfReg2 are driven combinationally with instRs1/instRs2 in the accept cycle, and with the latched values otherwise.
- READ: RF outputs are valid this cycle.
  - Capture issueRs1* from rs1*; if !instUseRs1 or rs1==0, force dirty=0, dep=0, value=0. Same rule for rs2.
  - issueRobId <= tail. Go to ISSUE.
- ISSUE, first cycle only:
  - rfUpdateValid=1, dest=rd, robId=tail, gated off when !instHasRd or rd==0.
  - tail <= tail+1, wrapping modulo 2^ROB_WIDTH.
  - The allocation counts into occupancy even when there is no rd.
- ISSUE, every cycle: issueValid=1 and all issue* outputs hold stable until issueReady. On the handshake, go to IDLE.
- Rename happens after capture, so an instruction with rd==rs1 sees the old producer.
- Throughput: one instruction per 3 cycles minimum (accept, read, issue+handshake).
- Occupancy:
  - +1 on allocation, -1 on robCommitValid; both in the same cycle leaves it unchanged.
  - Saturates at 0; a commit at 0 is ignored.
  - Full (occupancy == 2^ROB_WIDTH) blocks only acceptance; an instruction already in READ/ISSUE completes.
- Downstream CDB wakeup of captured dependencies between READ and issue is the reservation station's job.
- flushIn (sync):
  - state<=IDLE, issueValid<=0, tail<=0, occupancy<=0.
  - rfUpdateValid forced to 0 in that cycle; the in-flight instruction is dropped.
  - Flush beats commit and handshake in the same cycle.
- resetIn has priority over flushIn.
- Reset values: state IDLE, tail 0, occupancy 0, all issue* regs 0, issueValid 0, rfUpdateValid 0, rfReg1/rfReg2 0, instReady 0 during the reset cycle.

Test Plan:
- Reset, then inst rs1=5, rs2=6, rd=7, all use; RF returns clean 0x11/0x22 -> issue 2 cycles after accept with Rs1Value=0x11, Rs2Value=0x22, dirty=0, RobId=0; rfUpdateValid pulses once with dest=7, id=0.
- rs1=3 with rs1Dirty=1, dep=4; instUseRs2=0 with rs2=9 -> Rs1Dirty=1, Rs1Dep=4; Rs2Dirty=0, Rs2Value=0.
- rd=0 or instHasRd=0 -> no rfUpdateValid; RobId still allocated; next instruction gets id+1.
- Issue 16 instructions with no commits -> ids 0..15, instReady=0 afterwards. One robCommitValid -> instReady=1; next id=0 (wrap).
- issueReady held low 5 cycles in ISSUE -> issue* stable, rfUpdateValid high only in the first ISSUE cycle, tail advances once.
- flushIn during READ with occupancy=3 -> next cycle IDLE, issueValid=0, no rename, occupancy=0, next id=0. Flush and robCommitValid in the same cycle -> occupancy=0.

Source files
------------

// File: rtl/rename_dispatch_ctrl.sv
// Rename/dispatch sequencer: accepts one decoded instruction, reads its
// sources through the register file's registered read port, renames rd to
// a newly allocated ROB id and hands the packet to the reservation stations.
// Owns the ROB tail pointer and occupancy count, which back-pressure decode.
module rename_dispatch_ctrl #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 flushIn,
    input  logic                 instValid,
    output logic                 instReady,
    input  logic [4:0]           instRs1,
    input  logic [4:0]           instRs2,
    input  logic [4:0]           instRd,
    input  logic                 instUseRs1,
    input  logic                 instUseRs2,
    input  logic                 instHasRd,
    input  logic [31:0]          instPayload,
    output logic [4:0]           rfReg1,
    output logic [4:0]           rfReg2,
    input  logic                 rs1Dirty,
    input  logic [ROB_WIDTH-1:0] rs1Dependency,
    input  logic [31:0]          rs1Value,
    input  logic                 rs2Dirty,
    input  logic [ROB_WIDTH-1:0] rs2Dependency,
    input  logic [31:0]          rs2Value,
    output logic                 rfUpdateValid,
    output logic [4:0]           rfUpdateDest,
    output logic [ROB_WIDTH-1:0] rfUpdateRobId,
    input  logic                 robCommitValid,
    output logic                 issueValid,
    input  logic                 issueReady,
    output logic [ROB_WIDTH-1:0] issueRobId,
    output logic [4:0]           issueRd,
    output logic                 issueRs1Dirty,
    output logic [ROB_WIDTH-1:0] issueRs1Dep,
    output logic [31:0]          issueRs1Value,
    output logic                 issueRs2Dirty,
    output logic [ROB_WIDTH-1:0] issueRs2Dep,
    output logic [31:0]          issueRs2Value,
    output logic [31:0]          issuePayload
);

    // Occupancy is one bit wider than the id so "completely full" is representable.
    localparam logic [ROB_WIDTH:0] OCC_FULL = {1'b1, {ROB_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, ISSUE} state_t;

    state_t               state_q, state_d;
    logic [4:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                 use1_q, use1_d, use2_q, use2_d, has_rd_q, has_rd_d;
    logic [31:0]          payload_q, payload_d;
    logic                 first_q, first_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   occ_q, occ_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [ROB_WIDTH-1:0] issue_rob_id_q, issue_rob_id_d;
    logic [4:0]           issue_rd_q, issue_rd_d;
    logic                 issue_d1_q, issue_d1_d, issue_d2_q, issue_d2_d;
    logic [ROB_WIDTH-1:0] issue_p1_q, issue_p1_d, issue_p2_q, issue_p2_d;
    logic [31:0]          issue_v1_q, issue_v1_d, issue_v2_q, issue_v2_d;
    logic [31:0]          issue_pl_q, issue_pl_d;

    logic accept, alloc, src1_real, src2_real;

    assign instReady = (state_q == IDLE) && (occ_q < OCC_FULL) && !flushIn && !resetIn;
    assign accept    = instValid && instReady;
    // The single allocation point: first cycle in ISSUE, counted with or without rd.
    assign alloc     = (state_q == ISSUE) && first_q;
    assign src1_real = use1_q && (rs1_q != 5'd0);
    assign src2_real = use2_q && (rs2_q != 5'd0);

    // Read addresses bypass the latch in the accept cycle so RF data lands in READ.
    assign rfReg1 = accept ? instRs1 : rs1_q;
    assign rfReg2 = accept ? instRs2 : rs2_q;

    assign rfUpdateValid = alloc && has_rd_q && (rd_q != 5'd0) && !flushIn && !resetIn;
    assign rfUpdateDest  = rd_q;
    assign rfUpdateRobId = tail_q;

    assign issueValid    = issue_valid_q;
    assign issueRobId    = issue_rob_id_q;
    assign issueRd       = issue_rd_q;
    assign issueRs1Dirty = issue_d1_q;
    assign issueRs1Dep   = issue_p1_q;
    assign issueRs1Value = issue_v1_q;
    assign issueRs2Dirty = issue_d2_q;
    assign issueRs2Dep   = issue_p2_q;
    assign issueRs2Value = issue_v2_q;
    assign issuePayload  = issue_pl_q;

    // Next-state: FSM sequencing, operand capture, tail/occupancy bookkeeping, flush.
    always_comb begin
        state_d        = state_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        use1_d         = use1_q;
        use2_d         = use2_q;
        has_rd_d       = has_rd_q;
        payload_d      = payload_q;
        first_d        = first_q;
        tail_d         = tail_q;
        occ_d          = occ_q;
        issue_valid_d  = issue_valid_q;
        issue_rob_id_d = issue_rob_id_q;
        issue_rd_d     = issue_rd_q;
        issue_d1_d     = issue_d1_q;
        issue_p1_d     = issue_p1_q;
        issue_v1_d     = issue_v1_q;
        issue_d2_d     = issue_d2_q;
        issue_p2_d     = issue_p2_q;
        issue_v2_d     = issue_v2_q;
        issue_pl_d     = issue_pl_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rs1_d     = instRs1;
                    rs2_d     = instRs2;
                    rd_d      = instRd;
                    use1_d    = instUseRs1;
                    use2_d    = instUseRs2;
                    has_rd_d  = instHasRd;
                    payload_d = instPayload;
                    state_d   = READ;
                end
            end
            READ: begin
                // Capture precedes the rename, so rd==rs sees the old producer.
                issue_d1_d     = src1_real ? rs1Dirty      : 1'b0;
                issue_p1_d     = src1_real ? rs1Dependency : '0;
                issue_v1_d     = src1_real ? rs1Value      : 32'd0;
                issue_d2_d     = src2_real ? rs2Dirty      : 1'b0;
                issue_p2_d     = src2_real ? rs2Dependency : '0;
                issue_v2_d     = src2_real ? rs2Value      : 32'd0;
                issue_rob_id_d = tail_q;
                issue_rd_d     = has_rd_q ? rd_q : 5'd0;
                issue_pl_d     = payload_q;
                issue_valid_d  = 1'b1;
                first_d        = 1'b1;
                state_d        = ISSUE;
            end
            ISSUE: begin
                if (first_q) begin
                    tail_d  = tail_q + 1'b1;
                    first_d = 1'b0;
                end
                if (issueReady) begin
                    issue_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Allocate and commit in the same cycle cancel; a lone commit at zero is dropped.
        if (alloc && !robCommitValid)
            occ_d = occ_q + 1'b1;
        else if (!alloc && robCommitValid && (occ_q != '0))
            occ_d = occ_q - 1'b1;

        if (flushIn) begin
            state_d       = IDLE;
            issue_valid_d = 1'b0;
            first_d       = 1'b0;
            tail_d        = '0;
            occ_d         = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state_q        <= IDLE;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            use1_q         <= 1'b0;
            use2_q         <= 1'b0;
            has_rd_q       <= 1'b0;
            payload_q      <= '0;
            first_q        <= 1'b0;
            tail_q         <= '0;
            occ_q          <= '0;
            issue_valid_q  <= 1'b0;
            issue_rob_id_q <= '0;
            issue_rd_q     <= '0;
            issue_d1_q     <= 1'b0;
            issue_p1_q     <= '0;
            issue_v1_q     <= '0;
            issue_d2_q     <= 1'b0;
            issue_p2_q     <= '0;
            issue_v2_q     <= '0;
            issue_pl_q     <= '0;
        end else begin
            state_q        <= state_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            use1_q         <= use1_d;
            use2_q         <= use2_d;
            has_rd_q       <= has_rd_d;
            payload_q      <= payload_d;
            first_q        <= first_d;
            tail_q         <= tail_d;
            occ_q          <= occ_d;
            issue_valid_q  <= issue_valid_d;
            issue_rob_id_q <= issue_rob_id_d;
            issue_rd_q     <= issue_rd_d;
            issue_d1_q     <= issue_d1_d;
            issue_p1_q     <= issue_p1_d;
            issue_v1_q     <= issue_v1_d;
            issue_d2_q     <= issue_d2_d;
            issue_p2_q     <= issue_p2_d;
            issue_v2_q     <= issue_v2_d;
            issue_pl_q     <= issue_pl_d;
        end
    end

endmodule
